// File: rtl/cook_preset_sequencer.sv
// cook_preset_sequencer: one-touch preset cook programs.
// On a preset request, loads three BCD digits (mins, sec_tens, sec_ones) into
// the cook timer over its keypad-load interface and pulses start. While
// cooking, it gates the magnetron with a 10-slot power-level duty cycle.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   preset_req/sel       one-cycle request and preset index (IDLE only)
//   door_closed          door interlock, checked at request time
//   mag_on               magnetron enable from the cook controller
//   timer_done           timer reached 0:00
//   timer_number/loadn/pgt  BCD digit, active-low load, load strobe to timer
//   startn               active-low one-clock start pulse
//   mag_gate             mag_on AND active duty slot
//   busy, done, error    not-idle, completion pulse, sticky refusal flag
// All outputs are registered and follow their cause by one clock.
module cook_preset_sequencer #(
  parameter logic [11:0] PRESET0_TIME  = 12'h030,
  parameter logic [11:0] PRESET1_TIME  = 12'h100,
  parameter logic [11:0] PRESET2_TIME  = 12'h230,
  parameter logic [11:0] PRESET3_TIME  = 12'h500,
  parameter int unsigned PRESET0_POWER = 10,
  parameter int unsigned PRESET1_POWER = 10,
  parameter int unsigned PRESET2_POWER = 5,
  parameter int unsigned PRESET3_POWER = 3,
  parameter int unsigned SLOT_LEN      = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       preset_req,
  input  logic [1:0] preset_sel,
  input  logic       door_closed,
  input  logic       mag_on,
  input  logic       timer_done,
  output logic [3:0] timer_number,
  output logic       timer_loadn,
  output logic       timer_pgt,
  output logic       startn,
  output logic       mag_gate,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned SLOT_W    = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int unsigned NUM_SLOTS = 10;

  // Out-of-range power levels fall back to full power.
  localparam logic [3:0] PWR0 = (PRESET0_POWER >= 1 && PRESET0_POWER <= 10) ? 4'(PRESET0_POWER) : 4'd10;
  localparam logic [3:0] PWR1 = (PRESET1_POWER >= 1 && PRESET1_POWER <= 10) ? 4'(PRESET1_POWER) : 4'd10;
  localparam logic [3:0] PWR2 = (PRESET2_POWER >= 1 && PRESET2_POWER <= 10) ? 4'(PRESET2_POWER) : 4'd10;
  localparam logic [3:0] PWR3 = (PRESET3_POWER >= 1 && PRESET3_POWER <= 10) ? 4'(PRESET3_POWER) : 4'd10;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);
  localparam logic [3:0]        IDX_LAST  = 4'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_ARM,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t            state, state_d;
  logic [1:0]        digit_idx, digit_idx_d;
  logic [1:0]        phase, phase_d;
  logic [1:0]        arm_cnt, arm_cnt_d;
  logic [SLOT_W-1:0] slot_cnt, slot_cnt_d;
  logic [3:0]        slot_idx, slot_idx_d;
  logic [11:0]       time_q, time_d;
  logic [3:0]        power_q, power_d;

  logic [3:0] number_d;
  logic       loadn_d, pgt_d, startn_d, gate_d, busy_d, done_d, error_d;

  logic [11:0] sel_time;
  logic [3:0]  sel_power;
  logic [3:0]  cur_digit;

  // Preset table lookup for the requested index.
  always_comb begin
    sel_time  = PRESET0_TIME;
    sel_power = PWR0;
    case (preset_sel)
      2'd1:    begin sel_time = PRESET1_TIME; sel_power = PWR1; end
      2'd2:    begin sel_time = PRESET2_TIME; sel_power = PWR2; end
      2'd3:    begin sel_time = PRESET3_TIME; sel_power = PWR3; end
      default: begin sel_time = PRESET0_TIME; sel_power = PWR0; end
    endcase
  end

  // Digit order: mins, sec_tens, sec_ones.
  always_comb begin
    cur_digit = time_q[3:0];
    case (digit_idx)
      2'd0:    cur_digit = time_q[11:8];
      2'd1:    cur_digit = time_q[7:4];
      default: cur_digit = time_q[3:0];
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    digit_idx_d = digit_idx;
    phase_d     = phase;
    arm_cnt_d   = arm_cnt;
    slot_cnt_d  = slot_cnt;
    slot_idx_d  = slot_idx;
    time_d      = time_q;
    power_d     = power_q;
    error_d     = error;
    number_d    = 4'd0;
    loadn_d     = 1'b1;
    pgt_d       = 1'b0;
    startn_d    = 1'b1;
    gate_d      = 1'b0;
    busy_d      = (state != S_IDLE);
    done_d      = 1'b0;

    case (state)
      S_IDLE: begin
        if (preset_req) begin
          if (door_closed) begin
            time_d      = sel_time;
            power_d     = sel_power;
            error_d     = 1'b0;
            digit_idx_d = 2'd0;
            phase_d     = 2'd0;
            state_d     = S_LOAD;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      // Three clocks per digit: present, strobe, release.
      S_LOAD: begin
        number_d = cur_digit;
        case (phase)
          2'd0: begin
            loadn_d = 1'b0;
            phase_d = 2'd1;
          end
          2'd1: begin
            loadn_d = 1'b0;
            pgt_d   = 1'b1;
            phase_d = 2'd2;
          end
          default: begin
            phase_d = 2'd0;
            if (digit_idx == 2'd2) begin
              digit_idx_d = 2'd0;
              state_d     = S_START;
            end else begin
              digit_idx_d = digit_idx + 2'd1;
            end
          end
        endcase
      end

      S_START: begin
        startn_d  = 1'b0;
        arm_cnt_d = 2'd0;
        state_d   = S_ARM;
      end

      // Give the controller four clocks to raise mag_on.
      S_ARM: begin
        if (mag_on) begin
          slot_cnt_d = '0;
          slot_idx_d = 4'd0;
          state_d    = S_RUN;
        end else if (arm_cnt == 2'd3) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          arm_cnt_d = arm_cnt + 2'd1;
        end
      end

      // Counters advance only on clocks the magnetron is enabled, so a pause
      // resumes the duty phase exactly where it stopped.
      S_RUN: begin
        gate_d = mag_on && (slot_idx < power_q);
        if (timer_done) begin
          state_d = S_DONE;
        end else if (!mag_on) begin
          state_d = S_PAUSE;
        end else if (slot_cnt == SLOT_LAST) begin
          slot_cnt_d = '0;
          slot_idx_d = (slot_idx == IDX_LAST) ? 4'd0 : slot_idx + 4'd1;
        end else begin
          slot_cnt_d = slot_cnt + SLOT_W'(1);
        end
      end

      S_PAUSE: begin
        if (timer_done) begin
          state_d = S_DONE;
        end else if (mag_on) begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        done_d      = 1'b1;
        slot_cnt_d  = '0;
        slot_idx_d  = 4'd0;
        digit_idx_d = 2'd0;
        phase_d     = 2'd0;
        arm_cnt_d   = 2'd0;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      digit_idx    <= 2'd0;
      phase        <= 2'd0;
      arm_cnt      <= 2'd0;
      slot_cnt     <= '0;
      slot_idx     <= 4'd0;
      time_q       <= 12'd0;
      power_q      <= 4'd0;
      timer_number <= 4'd0;
      timer_loadn  <= 1'b1;
      timer_pgt    <= 1'b0;
      startn       <= 1'b1;
      mag_gate     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_d;
      digit_idx    <= digit_idx_d;
      phase        <= phase_d;
      arm_cnt      <= arm_cnt_d;
      slot_cnt     <= slot_cnt_d;
      slot_idx     <= slot_idx_d;
      time_q       <= time_d;
      power_q      <= power_d;
      timer_number <= number_d;
      timer_loadn  <= loadn_d;
      timer_pgt    <= pgt_d;
      startn       <= startn_d;
      mag_gate     <= gate_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
    end
  end

endmodule

// File: tb/tb_cook_preset_sequencer.sv
// Directed bench for cook_preset_sequencer (SLOT_LEN=2, default presets).
module tb_cook_preset_sequencer;

  logic       clock;
  logic       reset;
  logic       preset_req;
  logic [1:0] preset_sel;
  logic       door_closed;
  logic       mag_on;
  logic       timer_done;
  logic [3:0] timer_number;
  logic       timer_loadn;
  logic       timer_pgt;
  logic       startn;
  logic       mag_gate;
  logic       busy;
  logic       done;
  logic       error;

  int n_vec;
  int n_err;

  cook_preset_sequencer #(.SLOT_LEN(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .preset_req   (preset_req),
    .preset_sel   (preset_sel),
    .door_closed  (door_closed),
    .mag_on       (mag_on),
    .timer_done   (timer_done),
    .timer_number (timer_number),
    .timer_loadn  (timer_loadn),
    .timer_pgt    (timer_pgt),
    .startn       (startn),
    .mag_gate     (mag_gate),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Follows the 9-clock digit load and the start pulse that ends it.
  // With inject set, a second request (preset 0) arrives mid-load.
  task automatic expect_load(input logic [11:0] t, input bit inject);
    logic [3:0] dg;
    for (int d = 0; d < 3; d++) begin
      dg = (d == 0) ? t[11:8] : (d == 1) ? t[7:4] : t[3:0];
      for (int p = 0; p < 3; p++) begin
        if (inject && d == 0 && p == 1) begin
          preset_req = 1'b1;
          preset_sel = 2'd0;
        end
        step();
        preset_req = 1'b0;
        check("number", 32'(timer_number), 32'(dg));
        check("loadn", 32'(timer_loadn), (p == 2) ? 1 : 0);
        check("pgt", 32'(timer_pgt), (p == 1) ? 1 : 0);
        check("startn_load", 32'(startn), 1);
        check("busy_load", 32'(busy), 1);
      end
    end
    step();
    check("startn_low", 32'(startn), 0);
    step();
    check("startn_high", 32'(startn), 1);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    reset       = 1'b1;
    preset_req  = 1'b0;
    preset_sel  = 2'd0;
    door_closed = 1'b1;
    mag_on      = 1'b0;
    timer_done  = 1'b0;
    step();
    step();
    check("rst_number", 32'(timer_number), 0);
    check("rst_loadn", 32'(timer_loadn), 1);
    check("rst_pgt", 32'(timer_pgt), 0);
    check("rst_startn", 32'(startn), 1);
    check("rst_gate", 32'(mag_gate), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    reset = 1'b0;

    // Preset 1 (1:00); mag_on never comes, so ARM times out.
    preset_sel = 2'd1;
    preset_req = 1'b1;
    step();
    preset_req = 1'b0;
    check("busy_req_edge", 32'(busy), 0);
    expect_load(12'h100, 1'b0);
    step();
    step();
    check("arm_err_early", 32'(error), 0);
    step();
    check("arm_err_set", 32'(error), 1);
    check("arm_busy", 32'(busy), 1);
    step();
    check("arm_idle", 32'(busy), 0);

    // Preset 2 (2:30, power 5): 10 clocks on, 10 off with SLOT_LEN=2.
    preset_sel = 2'd2;
    preset_req = 1'b1;
    mag_on     = 1'b1;
    step();
    preset_req = 1'b0;
    check("err_cleared", 32'(error), 0);
    expect_load(12'h230, 1'b0);
    check("gate_arm", 32'(mag_gate), 0);
    for (int i = 0; i < 10; i++) begin step(); check("gate_on", 32'(mag_gate), 1); end
    for (int i = 0; i < 10; i++) begin step(); check("gate_off", 32'(mag_gate), 0); end
    for (int i = 0; i < 3; i++) begin step(); check("gate_on2", 32'(mag_gate), 1); end
    // Pause mid-slot for 7 clocks; the remaining 7 on-clocks must follow.
    mag_on = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check("gate_pause", 32'(mag_gate), 0);
      check("busy_pause", 32'(busy), 1);
    end
    mag_on = 1'b1;
    step();
    check("gate_resume_lag", 32'(mag_gate), 0);
    for (int i = 0; i < 7; i++) begin step(); check("gate_resume", 32'(mag_gate), 1); end
    step();
    check("gate_resume_off", 32'(mag_gate), 0);
    // timer_done coinciding with mag_on falling.
    mag_on     = 1'b0;
    timer_done = 1'b1;
    step();
    timer_done = 1'b0;
    check("done_early", 32'(done), 0);
    check("gate_done", 32'(mag_gate), 0);
    step();
    check("done_pulse", 32'(done), 1);
    check("done_busy", 32'(busy), 1);
    step();
    check("done_clear", 32'(done), 0);
    check("done_idle", 32'(busy), 0);

    // Door open: refused, no load activity.
    door_closed = 1'b0;
    preset_sel  = 2'd0;
    preset_req  = 1'b1;
    step();
    preset_req = 1'b0;
    check("door_err", 32'(error), 1);
    check("door_busy", 32'(busy), 0);
    check("door_loadn", 32'(timer_loadn), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("door_busy_hold", 32'(busy), 0);
      check("door_loadn_hold", 32'(timer_loadn), 1);
    end
    door_closed = 1'b1;

    // Preset 3 (5:00) with an ignored second request during LOAD.
    preset_sel = 2'd3;
    preset_req = 1'b1;
    step();
    preset_req = 1'b0;
    check("err_cleared2", 32'(error), 0);
    expect_load(12'h500, 1'b1);
    for (int i = 0; i < 4; i++) step();
    check("p3_idle", 32'(busy), 0);
    check("p3_arm_err", 32'(error), 1);

    // Preset 0 (0:30), reset on the strobe clock of the second digit.
    preset_sel = 2'd0;
    preset_req = 1'b1;
    step();
    preset_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("abort_pgt_pre", 32'(timer_pgt), 1);
    check("abort_num_pre", 32'(timer_number), 3);
    check("abort_loadn_pre", 32'(timer_loadn), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_pgt", 32'(timer_pgt), 0);
    check("abort_loadn", 32'(timer_loadn), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_number", 32'(timer_number), 0);
    for (int i = 0; i < 12; i++) begin
      step();
      check("abort_startn", 32'(startn), 1);
      check("abort_idle", 32'(busy), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
